delay_sched: RTL and testbench

- Programmable-delay pulse scheduler: the controller that sequences a delay line whose delay is set at run time, instead of the fixed 2-clock delay.
- Detects each rising edge on idata and emits a 1-cycle odata pulse exactly D clocks later.
- Holds up to DEPTH pending edges in a timestamp FIFO.
- Sits between stimulus/trigger sources and downstream logic that needs a timed strobe.

---
 rtl/delay_pkg.sv | 16 +
 rtl/ts_fifo.sv | 70 +++++++
 rtl/delay_sched.sv | 134 +++++++++++++
 tb/tb_delay_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared constants and control-state encoding for the programmable-delay pulse scheduler.
package delay_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = 2;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_RST = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/ts_fifo.sv
// DEPTH x W circular timestamp buffer; head visible combinationally, push/pop in the same cycle allowed.
// A push while full is only taken when a pop frees the head slot in the same cycle.
module ts_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Programmable-delay pulse scheduler: each rising edge of idata yields a 1-cycle odata pulse D clocks later.
// DELAY_SCHED_PULSE_CNT_EN adds a saturating 16-bit count of emitted pulses on opulse_cnt.
module delay_sched
  import delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             iclock,
  input  logic             ireset,
  input  logic             idata,
  input  logic [CNT_W-1:0] idelay,
  input  logic             iload,
  output logic             odata,
  output logic             obusy,
  output logic             ofull,
  output logic             ooverflow
`ifdef DELAY_SCHED_PULSE_CNT_EN
  ,
  output logic [15:0]      opulse_cnt
`endif
);

  logic             idata_q, idata_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             odata_q, odata_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;

  logic             edge_det, push, pop, drop;
  logic [CNT_W-1:0] due, head;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full, fifo_empty;

  assign edge_det = idata && !idata_q;
  assign due      = tcnt_q + delay_q;
  // Equality is wrap-safe since every pending due lies less than 2^CNT_W ahead.
  assign pop      = !fifo_empty && (head == tcnt_q);
  assign push     = edge_det && (!fifo_full || pop);
  assign drop     = edge_det && fifo_full && !pop;

  ts_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (iclock),
    .rst   (ireset),
    .push  (push),
    .pop   (pop),
    .wdata (due),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    idata_d = idata;
    tcnt_d  = tcnt_q + CNT_W'(1);
    odata_d = pop;
    ovf_d   = ovf_q || drop;
    delay_d = delay_q;
    // Loading only while idle keeps all pending entries on a single D, so FIFO order stays emission order.
    if (iload && (state_q == IDLE)) begin
      delay_d = (idelay == '0) ? CNT_W'(DELAY_MIN) : idelay;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      idata_q <= 1'b0;
      tcnt_q  <= '0;
      delay_q <= CNT_W'(DELAY_RST);
      odata_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idata_q <= idata_d;
      tcnt_q  <= tcnt_d;
      delay_q <= delay_d;
      odata_q <= odata_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = ACTIVE;
      ACTIVE:  if (pop && !push && (fifo_count == (PTR_W+1)'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obusy = (state_q == ACTIVE);
  end

  assign odata     = odata_q;
  assign ofull     = fifo_full;
  assign ooverflow = ovf_q;

`ifdef DELAY_SCHED_PULSE_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (odata_d && (pcnt_q != 16'hFFFF)) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign opulse_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Directed-vector bench for delay_sched; loop index i is the clock edge just taken after driving inputs.
module tb_delay_sched;

  logic       iclock = 1'b0;
  logic       ireset = 1'b1;
  logic       idata  = 1'b0;
  logic [7:0] idelay = 8'd0;
  logic       iload  = 1'b0;
  logic       odata, obusy, ofull, ooverflow;
`ifdef DELAY_SCHED_PULSE_CNT_EN
  logic [15:0] opulse_cnt;
`endif

  int checks = 0;
  int errors = 0;

  delay_sched dut (
    .iclock    (iclock),
    .ireset    (ireset),
    .idata     (idata),
    .idelay    (idelay),
    .iload     (iload),
    .odata     (odata),
    .obusy     (obusy),
    .ofull     (ofull),
    .ooverflow (ooverflow)
`ifdef DELAY_SCHED_PULSE_CNT_EN
    ,
    .opulse_cnt(opulse_cnt)
`endif
  );

  always #5 iclock = ~iclock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iclock);
      #1;
    end
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    idata  = 1'b0;
    iload  = 1'b0;
    idelay = 8'd0;
    step(2);
    ireset = 1'b0;
  endtask

  task automatic load_delay(input logic [7:0] d);
    iload  = 1'b1;
    idelay = d;
    step(1);
    iload  = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    ireset = 1'b1;
    #3;
    checks++;
    if ({odata, obusy, ofull, ooverflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000", {odata, obusy, ofull, ooverflow});
    end
    do_reset();
    step(3);
    checks++;
    if ({odata, obusy, ofull, ooverflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got %b want 0000", {odata, obusy, ofull, ooverflow});
    end
`ifdef DELAY_SCHED_PULSE_CNT_EN
    checks++;
    if (opulse_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_pcnt: got %0d want 0", opulse_cnt);
    end
`endif
  endtask

  task automatic test_default_delay();
    logic eo, eb;
    do_reset();
    step(1);
    for (int i = 0; i < 7; i++) begin
      idata = (i == 0);
      step(1);
      eo = (i == 2);
      eb = (i < 2);
      checks++;
      if (odata !== eo || obusy !== eb) begin
        errors++;
        $display("FAIL default_d2 i=%0d: odata/obusy %b%b want %b%b", i, odata, obusy, eo, eb);
      end
    end
  endtask

  task automatic test_load_d5();
    logic eo;
    do_reset();
    load_delay(8'd5);
    for (int i = 0; i < 15; i++) begin
      idata = (i == 0 || i == 3 || i == 6);
      step(1);
      eo = (i == 5 || i == 8 || i == 11);
      checks++;
      if (odata !== eo || ofull !== 1'b0 || ooverflow !== 1'b0) begin
        errors++;
        $display("FAIL load_d5 i=%0d: odata/ofull/ovf %b%b%b want %b00", i, odata, ofull, ooverflow, eo);
      end
    end
`ifdef DELAY_SCHED_PULSE_CNT_EN
    checks++;
    if (opulse_cnt !== 16'd3) begin
      errors++;
      $display("FAIL load_d5_pcnt: got %0d want 3", opulse_cnt);
    end
`endif
  endtask

  task automatic test_held_high();
    logic eo;
    do_reset();
    step(1);
    for (int i = 0; i < 10; i++) begin
      idata = (i < 6);
      step(1);
      eo = (i == 2);
      checks++;
      if (odata !== eo) begin
        errors++;
        $display("FAIL held_high i=%0d: odata %b want %b", i, odata, eo);
      end
    end
  endtask

  task automatic test_overflow();
    logic eo, ef, ev, eb;
    int   npulse;
    npulse = 0;
    do_reset();
    load_delay(8'd20);
    for (int i = 0; i < 32; i++) begin
      idata = (i <= 8) && (i % 2 == 0);
      step(1);
      eo = (i == 20 || i == 22 || i == 24 || i == 26);
      ef = (i >= 6 && i <= 19);
      ev = (i >= 8);
      eb = (i <= 25);
      if (odata === 1'b1) npulse++;
      checks++;
      if (odata !== eo || ofull !== ef || ooverflow !== ev || obusy !== eb) begin
        errors++;
        $display("FAIL overflow i=%0d: odata/full/ovf/busy %b%b%b%b want %b%b%b%b",
                 i, odata, ofull, ooverflow, obusy, eo, ef, ev, eb);
      end
    end
    checks++;
    if (npulse != 4) begin
      errors++;
      $display("FAIL overflow_count: got %0d pulses want 4", npulse);
    end
  endtask

  task automatic test_full_push_pop();
    logic eo, ef, eb;
    do_reset();
    load_delay(8'd8);
    for (int i = 0; i < 20; i++) begin
      idata = (i <= 8) && (i % 2 == 0);
      step(1);
      eo = (i >= 8 && i <= 16 && (i % 2 == 0));
      ef = (i >= 6 && i <= 9);
      eb = (i <= 15);
      checks++;
      if (odata !== eo || ofull !== ef || obusy !== eb || ooverflow !== 1'b0) begin
        errors++;
        $display("FAIL full_push_pop i=%0d: odata/full/busy/ovf %b%b%b%b want %b%b%b0",
                 i, odata, ofull, obusy, ooverflow, eo, ef, eb);
      end
    end
  endtask

  task automatic test_load_ignored();
    logic eo;
    do_reset();
    load_delay(8'd4);
    idelay = 8'd9;
    for (int i = 0; i < 26; i++) begin
      idata = (i == 0 || i == 6 || i == 14);
      iload = (i == 1 || i == 12);
      step(1);
      eo = (i == 4 || i == 10 || i == 23);
      checks++;
      if (odata !== eo) begin
        errors++;
        $display("FAIL load_ignored i=%0d: odata %b want %b", i, odata, eo);
      end
    end
    iload = 1'b0;
  endtask

  task automatic test_wrap();
    logic eo;
    do_reset();
    iload  = 1'b1;
    idelay = 8'd10;
    step(1);
    iload  = 1'b0;
    step(249);
    for (int i = 0; i < 25; i++) begin
      idata  = (i == 0 || i == 20);
      iload  = (i == 15);
      idelay = 8'd0;
      step(1);
      eo = (i == 10 || i == 21);
      checks++;
      if (odata !== eo) begin
        errors++;
        $display("FAIL wrap i=%0d: odata %b want %b", i, odata, eo);
      end
    end
    iload = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_delay(8'd10);
    for (int i = 0; i < 6; i++) begin
      idata = (i == 0 || i == 2 || i == 4);
      step(1);
    end
    checks++;
    if (obusy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy_before: got %b want 1", obusy);
    end
    #2;
    ireset = 1'b1;
    #1;
    checks++;
    if ({odata, obusy, ofull, ooverflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async: got %b want 0000", {odata, obusy, ofull, ooverflow});
    end
    step(1);
    ireset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      checks++;
      if (odata !== 1'b0 || obusy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after i=%0d: odata/busy %b%b want 00", i, odata, obusy);
      end
    end
`ifdef DELAY_SCHED_PULSE_CNT_EN
    checks++;
    if (opulse_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_pcnt: got %0d want 0", opulse_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_default_delay();
    test_load_d5();
    test_held_high();
    test_overflow();
    test_full_push_pop();
    test_load_ignored();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
